// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall/flush controller beside the ID stage: load-use and
// branch-operand stalls, control flushes and memory-wait freezes. Optional stats via HAZARD_STATS_EN.
module hazard_stall_ctrl #(
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_use_rs,
    input  logic             IF_ID_use_rt,
    input  logic             IF_ID_branch,
    input  logic             IF_ID_jump,
    input  logic             ID_EX_mem_rd,
    input  logic             ID_EX_reg_wr,
    input  logic [4:0]       ID_EX_reg_wr_addr,
    input  logic             EX_MEM_mem_rd,
    input  logic [4:0]       EX_MEM_reg_wr_addr,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_wr,
    output logic             IF_ID_wr,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0] st, st_next;
    logic [1:0] cnt, cnt_next;
    logic [1:0] need;
    logic       match_ex, match_mem, br_id;

    assign br_id = (BRANCH_IN_ID != 0) && IF_ID_branch;

    always_comb begin
        match_ex  = (ID_EX_reg_wr_addr != 5'd0) &&
                    ((IF_ID_use_rs && (IF_ID_rs == ID_EX_reg_wr_addr)) ||
                     (IF_ID_use_rt && (IF_ID_rt == ID_EX_reg_wr_addr)));
        match_mem = (EX_MEM_reg_wr_addr != 5'd0) &&
                    ((IF_ID_use_rs && (IF_ID_rs == EX_MEM_reg_wr_addr)) ||
                     (IF_ID_use_rt && (IF_ID_rt == EX_MEM_reg_wr_addr)));
    end

    always_comb begin
        need = 2'd0;
        if (br_id && ID_EX_mem_rd && match_ex)
            need = 2'd2;
        else if (ID_EX_mem_rd && match_ex)
            need = 2'd1;
        else if (br_id && ID_EX_reg_wr && match_ex)
            need = 2'd1;
        else if (br_id && EX_MEM_mem_rd && match_mem)
            need = 2'd1;
    end

    always_comb begin
        PC_wr       = 1'b1;
        IF_ID_wr    = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            PC_wr       = 1'b0;
            IF_ID_wr    = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (mem_busy) begin
            PC_wr       = 1'b0;
            IF_ID_wr    = 1'b0;
            pipe_freeze = 1'b1;
        end else if (st == STALL || need != 2'd0) begin
            PC_wr       = 1'b0;
            IF_ID_wr    = 1'b0;
            ID_EX_flush = 1'b1;
        end else if ((IF_ID_branch && branch_taken) || IF_ID_jump) begin
            IF_ID_flush = 1'b1;
        end
    end

    // A single-bubble stall stays in RUN: the dependence has cleared when re-evaluated next cycle.
    always_comb begin
        st_next  = st;
        cnt_next = cnt;
        if (!mem_busy) begin
            if (st == STALL) begin
                if (cnt <= 2'd1) begin
                    st_next  = RUN;
                    cnt_next = 2'd0;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end else if (need == 2'd2) begin
                st_next  = STALL;
                cnt_next = 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= RUN;
            cnt <= 2'd0;
        end else begin
            st  <= st_next;
            cnt <= cnt_next;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ID_EX_flush && !mem_busy)
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (IF_ID_flush)
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
